// File: rtl/mmr_initiator_pkg.sv
// Shared types for the memory-mapped register bus initiator: FSM states,
// bus rw encoding, command record and the video block base address.
package mmr_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_TURN   = 2'd3
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam logic [31:0] VIDEO_ADDR = 32'h000B_8000;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

endpackage

// File: rtl/mmr_initiator_wait_counter.sv
// Down-counter that times the bus access window: load, decrement, zero flag.
// Saturates at zero so a stray decrement cannot wrap the window.
module mmr_initiator_wait_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mmr_initiator.sv
// Register-bus master: one command at a time, bus held WAIT_CYCLES+1 cycles, response after.
// Latency: accept edge N -> rsp_valid after edge N+WAIT_CYCLES+1; req_ready low until back in IDLE.
// Backpressure: rsp_ready low holds RESP; MMR_INITIATOR_TURNAROUND_EN adds one idle TURN cycle after it.
module mmr_initiator
  import mmr_initiator_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        bus_enable,
  output logic        bus_rw,
  output logic [31:0] bus_addr,
  inout  wire  [31:0] bus_data
);

  if (WAIT_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
    $error("mmr_initiator: WAIT_CYCLES does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;

  mmr_initiator_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (WAIT_LD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rdata_d   = rdata_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cmd_d    = '{rw: req_rw, addr: req_addr, wdata: req_wdata};
          cnt_load = 1'b1;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // read data is sampled on the edge that closes the window
        if (cnt_zero) begin
          rdata_d = (cmd_q.rw == RW_WRITE) ? 32'h0 : bus_data;
          state_d = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
`ifdef MMR_INITIATOR_TURNAROUND_EN
          state_d = ST_TURN;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
    end
  end

  // bus pins decode straight from state so reset releases them without a clock
  assign bus_enable = (state_q == ST_ACCESS);
  assign bus_rw     = bus_enable ? cmd_q.rw : RW_READ;
  assign bus_addr   = bus_enable ? cmd_q.addr : 32'h0;
  assign bus_data   = (bus_enable && (cmd_q.rw == RW_WRITE)) ? cmd_q.wdata : 32'hz;
  assign rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_mmr_initiator.sv
// Bench for mmr_initiator: an mmr responder at VIDEO_ADDR plus a second instance with no wait cycles.
module tb_mmr_initiator;
  import mmr_initiator_pkg::*;

  localparam int W_A = 2;
`ifdef MMR_INITIATOR_TURNAROUND_EN
  localparam int EXP_GAP  = 3;
  localparam bit HAS_TURN = 1'b1;
`else
  localparam int EXP_GAP  = 2;
  localparam bit HAS_TURN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_rw, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, bus_enable, bus_rw;
  logic [31:0] rsp_rdata, bus_addr;
  wire  [31:0] bus_data;

  logic        req_valid_b, req_rw_b, rsp_ready_b;
  logic [31:0] req_addr_b, req_wdata_b;
  logic        req_ready_b, rsp_valid_b, bus_enable_b, bus_rw_b;
  logic [31:0] rsp_rdata_b, bus_addr_b;
  wire  [31:0] bus_data_b;

  logic [31:0] mmr_val;
  logic        probe_en;
  logic [31:0] reg_model;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mmr_initiator #(.WAIT_CYCLES(W_A), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .bus_enable(bus_enable), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_data(bus_data)
  );

  mmr_initiator #(.WAIT_CYCLES(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_rw(req_rw_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
    .bus_enable(bus_enable_b), .bus_rw(bus_rw_b), .bus_addr(bus_addr_b), .bus_data(bus_data_b)
  );

  // responder: register at VIDEO_ADDR, any other address reads back ~addr;
  // the probe drives 0 on an otherwise released bus so a stray master drive shows up
  assign bus_data = (bus_enable && bus_rw == RW_READ) ? ((bus_addr == VIDEO_ADDR) ? mmr_val : ~bus_addr)
                                                      : (probe_en ? 32'h0 : 32'hz);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mmr_val <= 32'h0;
    else if (bus_enable && bus_rw == RW_WRITE && bus_addr == VIDEO_ADDR) mmr_val <= bus_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drives one command through instance A; observations are returned, not judged
  task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_bus, input int dly,
                         output logic [31:0] rdata, output int en_cycles, output bit rsp_seen,
                         output int bus_bad, output int bp_bad, output bit timed_out);
    int n;
    logic [31:0] held;
    timed_out = 1'b0; bus_bad = 0; bp_bad = 0; en_cycles = 0; rsp_seen = 1'b0; rdata = 32'h0;
    req_rw = rw; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    if (!req_ready) begin timed_out = 1'b1; req_valid = 1'b0; return; end
    tick();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rw = $urandom_range(0, 1);
    while (bus_enable && en_cycles < 50) begin
      if (bus_data !== exp_bus || bus_addr !== addr || bus_rw !== rw) bus_bad++;
      en_cycles++;
      tick();
    end
    rsp_seen = rsp_valid;
    held = rsp_rdata;
    for (int i = 0; i < dly; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0 || bus_enable !== 1'b0) bp_bad++;
      tick();
    end
    rdata = rsp_rdata;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    checks++; if (bus_enable !== 1'b0 || bus_rw !== 1'b0) begin errors++; $display("FAIL reset_bus_ctl: got en=%b rw=%b want 0 0", bus_enable, bus_rw); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
    checks++; if (bus_data !== 32'h0) begin errors++; $display("FAIL reset_bus_data_released: got %h want 0 (probe only)", bus_data); end
    checks++; if (req_ready_b !== 1'b1) begin errors++; $display("FAIL reset_req_ready_b: got %b want 1", req_ready_b); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    probe_en = 1'b0;
    reg_model = 32'h0;
  endtask

  task automatic test_idle();
    probe_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus_enable !== 1'b0 || bus_data !== 32'h0 || rsp_valid !== 1'b0)
        begin errors++; $display("FAIL idle_cycle%0d: got en=%b data=%h rsp_valid=%b want 0 0 0", i, bus_enable, bus_data, rsp_valid); end
    end
    probe_en = 1'b0;
  endtask

  task automatic test_write();
    logic [31:0] rd; int en, bb, bp; bit rs, to;
    run_txn(RW_WRITE, VIDEO_ADDR, 32'h12345678, 32'h12345678, 0, rd, en, rs, bb, bp, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL write_timeout: got %b want 0", to); end
    checks++; if (en !== W_A + 1) begin errors++; $display("FAIL write_enable_cycles: got %0d want %0d", en, W_A + 1); end
    checks++; if (rs !== 1'b1) begin errors++; $display("FAIL write_rsp_valid: got %b want 1", rs); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL write_rsp_rdata: got %h want 0", rd); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL write_bus_cycles: got %0d bad cycles want 0", bb); end
    checks++; if (mmr_val !== 32'h12345678) begin errors++; $display("FAIL write_responder_val: got %h want 12345678", mmr_val); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL write_rsp_drop: got %b want 0", rsp_valid); end
    checks++; if (req_ready !== !HAS_TURN) begin errors++; $display("FAIL write_after_ready: got %b want %b", req_ready, !HAS_TURN); end
    reg_model = 32'h12345678;
  endtask

  task automatic test_read();
    logic [31:0] rd; int en, bb, bp; bit rs, to;
    run_txn(RW_WRITE, VIDEO_ADDR, 32'hDEADBEEF, 32'hDEADBEEF, 0, rd, en, rs, bb, bp, to);
    reg_model = 32'hDEADBEEF;
    // wdata is the complement of the responder value so any master drive corrupts the bus
    run_txn(RW_READ, VIDEO_ADDR, 32'h21524110, 32'hDEADBEEF, 0, rd, en, rs, bb, bp, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL read_timeout: got %b want 0", to); end
    checks++; if (en !== W_A + 1) begin errors++; $display("FAIL read_enable_cycles: got %0d want %0d", en, W_A + 1); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL read_bus_cycles: got %0d bad cycles want 0", bb); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rsp_rdata: got %h want deadbeef", rd); end
    tick(); tick(); tick();
    checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata_hold: got %h want deadbeef", rsp_rdata); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; int en, bb, bp; bit rs, to;
    run_txn(RW_READ, VIDEO_ADDR, 32'h0, reg_model, 5, rd, en, rs, bb, bp, to);
    checks++; if (rs !== 1'b1 || to !== 1'b0) begin errors++; $display("FAIL bp_rsp_valid: got valid=%b timeout=%b want 1 0", rs, to); end
    checks++; if (bp !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bp); end
    checks++; if (rd !== reg_model) begin errors++; $display("FAIL bp_rdata: got %h want %h", rd, reg_model); end
  endtask

  task automatic test_back_to_back();
    bit en_hist[24];
    int acc, pulses, start1, start2, w1, w2, gap;
    acc = 0;
    req_rw_b = RW_WRITE; req_addr_b = VIDEO_ADDR; req_wdata_b = $urandom; req_valid_b = 1'b1;
    for (int i = 0; i < 24; i++) begin
      en_hist[i] = bus_enable_b;
      if (req_valid_b && req_ready_b) acc++;
      tick();
      if (acc == 2) req_valid_b = 1'b0;
    end
    req_valid_b = 1'b0;
    pulses = 0; start1 = -1; start2 = -1; w1 = 0; w2 = 0;
    for (int i = 0; i < 24; i++) begin
      if (en_hist[i] && (i == 0 || !en_hist[i-1])) begin
        pulses++;
        if (pulses == 1) start1 = i; else if (pulses == 2) start2 = i;
      end
      if (en_hist[i]) begin
        if (pulses == 1) w1++; else if (pulses == 2) w2++;
      end
    end
    gap = start2 - (start1 + w1);
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    checks++; if (w1 !== 1 || w2 !== 1) begin errors++; $display("FAIL b2b_width: got %0d,%0d want 1,1", w1, w2); end
    checks++; if (gap !== EXP_GAP) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", gap, EXP_GAP); end
    checks++; if (rsp_rdata_b !== 32'h0) begin errors++; $display("FAIL b2b_rdata: got %h want 0", rsp_rdata_b); end
  endtask

  task automatic test_reset_midflight();
    int n, bad;
    tick();
    req_rw = RW_WRITE; req_addr = VIDEO_ADDR; req_wdata = 32'hAAAA5555; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
    tick();
    #2;
    reset_n = 1'b0; probe_en = 1'b1;
    #1;
    checks++; if (bus_enable !== 1'b0) begin errors++; $display("FAIL rst_mid_enable: got %b want 0", bus_enable); end
    checks++; if (bus_data !== 32'h0) begin errors++; $display("FAIL rst_mid_bus_data: got %h want 0 (probe only)", bus_data); end
    tick();
    reset_n = 1'b1; probe_en = 1'b0;
    reg_model = 32'h0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid !== 1'b0 || bus_enable !== 1'b0 || req_ready !== 1'b1) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_mid_after: got %0d cycles with rsp/bus activity want 0", bad); end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wdata, exp; logic rw; int en, bb, bp, dly; bit rs, to;
    for (int t = 0; t < 24; t++) begin
      rw    = $urandom_range(0, 1);
      addr  = ($urandom_range(0, 2) != 0) ? VIDEO_ADDR : $urandom;
      wdata = $urandom;
      dly   = $urandom_range(0, 3);
      exp   = (rw == RW_WRITE) ? wdata : ((addr == VIDEO_ADDR) ? reg_model : ~addr);
      run_txn(rw, addr, wdata, exp, dly, rd, en, rs, bb, bp, to);
      checks++;
      if (to || en != W_A + 1 || !rs || bb != 0 || bp != 0)
        begin errors++; $display("FAIL rand%0d_shape: got to=%b en=%0d rsp=%b busbad=%0d bpbad=%0d want 0 %0d 1 0 0", t, to, en, rs, bb, bp, W_A + 1); end
      checks++;
      if (rd !== ((rw == RW_WRITE) ? 32'h0 : exp))
        begin errors++; $display("FAIL rand%0d_rdata: got %h want %h", t, rd, (rw == RW_WRITE) ? 32'h0 : exp); end
      if (rw == RW_WRITE && addr == VIDEO_ADDR) reg_model = wdata;
    end
  endtask

  initial begin
    req_valid = 1'b0; req_rw = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    req_valid_b = 1'b0; req_rw_b = 1'b0; req_addr_b = 32'h0; req_wdata_b = 32'h0; rsp_ready_b = 1'b1;
    probe_en = 1'b1; reg_model = 32'h0;
    test_reset();
    test_idle();
    test_write();
    test_read();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
